am_query_arbiter: RTL and testbench
===================================

Name: am_query_arbiter

Overview:
- Shares one associative memory (AM) instance between NUM_REQ query sources, for example per-sensor encoders, using round-robin arbitration.
- Accepts one query hypervector at a time, issues it to the AM over its valid/ready handshake, and waits for the A/V label and distance result.
- Returns the result to the requester that issued the query, tagged with that requester's index.
- Sits between the spatial/temporal encoders and the associative_memory block.

Parameters:
- NUM_REQ, 4: number of requesters (2..16; need not be a power of 2).
- HV_DIM, `HV_DIMENSION: hypervector width in bits.
- LABEL_W, `LABEL_WIDTH: label width.
- DIST_W, `DISTANCE_WIDTH: distance width.
- ID_W, `ceilLog2(NUM_REQ): requester index width.

Ports:
- Clk_CI  in  1  clock, rising edge.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- ReqValid_SI  in  NUM_REQ  per-requester query valid.
- ReqReady_SO  out  NUM_REQ  per-requester query accept.
- ReqHypervector_DI  in  NUM_REQ*HV_DIM  flattened queries; requester i occupies bits [i*HV_DIM +: HV_DIM].
- AmValid_SO  out  1  query valid to AM.
- AmReady_SI  in  1  AM ready for query.
- AmHypervector_DO  out  HV_DIM  latched query to AM.
- AmValid_SI  in  1  AM result valid.
- AmReady_SO  out  1  arbiter accepts AM result.
- AmLabelA_DI, AmLabelV_DI  in  LABEL_W  AM labels.
- AmDistA_DI, AmDistV_DI  in  DIST_W  AM distances.
- RespValid_SO  out  NUM_REQ  one-hot response valid.
- RespReady_SI  in  NUM_REQ  per-requester response accept.
- RespId_DO  out  ID_W  index of the responding requester.
- RespLabelA_DO, RespLabelV_DO  out  LABEL_W  latched labels.
- RespDistA_DO, RespDistV_DO  out  DIST_W  latched distances.
- QueryCount_DO  out  16  completed-query counter; saturates at 0xFFFF.
- Busy_SO  out  1  high whenever state != IDLE.

Behaviour:
- Reset (Rst_RBI low, takes effect immediately):
  - state=IDLE, round-robin pointer Ptr=0, Id=0.
  - All result and query registers, RespId_DO and QueryCount_DO are 0.
  - All valid/ready outputs are 0 except as state IDLE dictates.
  - A query already in flight is abandoned; the AM is expected to be reset by the same system reset.
- States: IDLE, ISSUE, WAIT_RES, RESPOND.
- IDLE:
  - Winner W is the first i with ReqValid_SI[i]=1, scanning Ptr, Ptr+1, … modulo NUM_REQ.
  - ReqReady_SO is one-hot at W, combinationally, and only when at least one request is valid. Otherwise it is all zero.
  - On a valid request: latch ReqHypervector_DI[W] into the query register, set Id=W, go to ISSUE.
  - AmReady_SO=0 in IDLE, so a stray AmValid_SI is ignored.
- ISSUE:
  - AmValid_SO=1 and AmHypervector_DO = query register, held stable.
  - On AmReady_SI=1, go to WAIT_RES.
  - First AmValid_SO occurs 1 cycle after the request handshake.
- WAIT_RES:
  - AmReady_SO=1.
  - On AmValid_SI=1: latch the four result fields, go to RESPOND.
  - Latching and AmReady_SO happen in the same cycle, consuming the AM result.
- RESPOND:
  - RespValid_SO[Id]=1; all other bits are 0. RespId_DO=Id.
  - Result outputs are held until RespReady_SI[Id]=1.
  - On handshake: Ptr = (Id+1) mod NUM_REQ, QueryCount_DO increments unless already 0xFFFF, go to IDLE.
  - RespReady_SI bits of other requesters are ignored.
- Fairness and throughput:
  - A requester granted once cannot win again until every other requester asserting valid has been served.
  - No new request is accepted before the previous response is consumed, so at most one query is outstanding.
  - Minimum cycles per query is 4 plus the AM processing time.
- Ptr wrap is an explicit compare against NUM_REQ-1, not a natural overflow.
- RespId_DO, the result outputs and AmHypervector_DO keep their last values outside the states that use them.

Test Plan:
- Single query: ReqValid[2]=1 with HV=pattern P, AM model returns LabelA=3, DistA=120 after 10 cycles → ReqReady[2] pulses in cycle 0; AmValid_SO rises in cycle 1 with AmHypervector_DO=P; RespValid[2] is high with RespId=2, LabelA=3, DistA=120; QueryCount=1.
- Simultaneous requests: all 4 valid and held, responses accepted immediately → grant order 0,1,2,3, then 0 again. Each RespId matches its grant.
- Round-robin pointer: after serving requester 2, requesters 1 and 3 both valid → 3 is served before 1.
- Backpressure: AmReady_SI held low for 5 cycles in ISSUE, then RespReady held low for 7 cycles in RESPOND → AmValid_SO and AmHypervector_DO stay stable throughout; response fields stay constant; no second ReqReady is asserted.
- Stray result: AmValid_SI pulsed while in IDLE → AmReady_SO=0, no state change, QueryCount unchanged.
- Reset mid-operation: Rst_RBI asserted low in WAIT_RES → outputs clear asynchronously, before the next clock edge. After release: state IDLE, Ptr=0, QueryCount=0, next grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/am_query_arbiter.sv
// am_query_arbiter: shares one associative memory between NUM_REQ query
// sources. A round-robin winner is accepted in IDLE, its query is issued to
// the AM, the result is captured and returned to the issuing requester. Only
// one query is outstanding at any time.

`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 8
`endif

module am_query_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int HV_DIM  = `HV_DIMENSION,
   parameter int LABEL_W = `LABEL_WIDTH,
   parameter int DIST_W  = `DISTANCE_WIDTH,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RBI,
   input  logic [NUM_REQ-1:0]        ReqValid_SI,
   output logic [NUM_REQ-1:0]        ReqReady_SO,
   input  logic [NUM_REQ*HV_DIM-1:0] ReqHypervector_DI,
   output logic                      AmValid_SO,
   input  logic                      AmReady_SI,
   output logic [HV_DIM-1:0]         AmHypervector_DO,
   input  logic                      AmValid_SI,
   output logic                      AmReady_SO,
   input  logic [LABEL_W-1:0]        AmLabelA_DI,
   input  logic [LABEL_W-1:0]        AmLabelV_DI,
   input  logic [DIST_W-1:0]         AmDistA_DI,
   input  logic [DIST_W-1:0]         AmDistV_DI,
   output logic [NUM_REQ-1:0]        RespValid_SO,
   input  logic [NUM_REQ-1:0]        RespReady_SI,
   output logic [ID_W-1:0]           RespId_DO,
   output logic [LABEL_W-1:0]        RespLabelA_DO,
   output logic [LABEL_W-1:0]        RespLabelV_DO,
   output logic [DIST_W-1:0]         RespDistA_DO,
   output logic [DIST_W-1:0]         RespDistV_DO,
   output logic [15:0]               QueryCount_DO,
   output logic                      Busy_SO
);

   // Candidate index needs one extra bit so ptr + k never overflows before the wrap compare.
   localparam int CAND_W = ID_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RES = 2'd2,
      ST_RESPOND  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [HV_DIM-1:0]    query_q, query_d;
   logic [LABEL_W-1:0]   label_a_q, label_a_d;
   logic [LABEL_W-1:0]   label_v_q, label_v_d;
   logic [DIST_W-1:0]    dist_a_q, dist_a_d;
   logic [DIST_W-1:0]    dist_v_q, dist_v_d;
   logic [15:0]          count_q, count_d;

   logic                 win_found_s;
   logic [ID_W-1:0]      win_idx_s;
   logic [HV_DIM-1:0]    win_hv_s;
   logic [CAND_W-1:0]    cand_sum_s;
   logic [CAND_W-1:0]    cand_s;
   logic                 hit_s;

   // Round-robin search: first valid requester scanning from ptr, wrapping by explicit compare.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_sum_s  = '0;
      cand_s      = '0;
      hit_s       = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_sum_s  = {1'b0, ptr_q} + CAND_W'(k);
         cand_s      = (cand_sum_s >= CAND_W'(NUM_REQ)) ? (cand_sum_s - CAND_W'(NUM_REQ)) : cand_sum_s;
         hit_s       = ReqValid_SI[cand_s[ID_W-1:0]] & ~win_found_s;
         win_idx_s   = hit_s ? cand_s[ID_W-1:0] : win_idx_s;
         win_found_s = win_found_s | ReqValid_SI[cand_s[ID_W-1:0]];
      end
   end

   // Select the winning requester's hypervector from the flattened input bus.
   always_comb begin
      win_hv_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_hv_s = (win_idx_s == ID_W'(i)) ? ReqHypervector_DI[i*HV_DIM +: HV_DIM] : win_hv_s;
      end
   end

   // One-hot grant in IDLE and one-hot response strobe in RESPOND.
   always_comb begin
      ReqReady_SO  = '0;
      RespValid_SO = '0;
      if ((state_q == ST_IDLE) && win_found_s) begin
         ReqReady_SO[win_idx_s] = 1'b1;
      end else begin
         ReqReady_SO = '0;
      end
      if (state_q == ST_RESPOND) begin
         RespValid_SO[id_q] = 1'b1;
      end else begin
         RespValid_SO = '0;
      end
   end

   assign AmValid_SO       = (state_q == ST_ISSUE);
   assign AmReady_SO       = (state_q == ST_WAIT_RES);
   assign Busy_SO          = (state_q != ST_IDLE);
   assign AmHypervector_DO = query_q;
   assign RespId_DO        = id_q;
   assign RespLabelA_DO    = label_a_q;
   assign RespLabelV_DO    = label_v_q;
   assign RespDistA_DO     = dist_a_q;
   assign RespDistV_DO     = dist_v_q;
   assign QueryCount_DO    = count_q;

   // Next-state logic: accept, issue, collect result, hand back and advance the pointer.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      query_d   = query_q;
      label_a_d = label_a_q;
      label_v_d = label_v_q;
      dist_a_d  = dist_a_q;
      dist_v_d  = dist_v_q;
      count_d   = count_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) begin
               query_d = win_hv_s;
               id_d    = win_idx_s;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (AmReady_SI) begin
               state_d = ST_WAIT_RES;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT_RES: begin
            if (AmValid_SI) begin
               label_a_d = AmLabelA_DI;
               label_v_d = AmLabelV_DI;
               dist_a_d  = AmDistA_DI;
               dist_v_d  = AmDistV_DI;
               state_d   = ST_RESPOND;
            end else begin
               state_d = ST_WAIT_RES;
            end
         end
         ST_RESPOND: begin
            if (RespReady_SI[id_q]) begin
               ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : (id_q + ID_W'(1));
               count_d = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESPOND;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any query in flight.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         id_q      <= '0;
         query_q   <= '0;
         label_a_q <= '0;
         label_v_q <= '0;
         dist_a_q  <= '0;
         dist_v_q  <= '0;
         count_q   <= 16'd0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         query_q   <= query_d;
         label_a_q <= label_a_d;
         label_v_q <= label_v_d;
         dist_a_q  <= dist_a_d;
         dist_v_q  <= dist_v_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_am_query_arbiter.sv
// Testbench for am_query_arbiter: a behavioural AM responder plus a scoreboard
// of expected responses, pushed when a grant is seen and popped on response.

module tb_am_query_arbiter;

   localparam int NR = 4;
   localparam int HV = 64;
   localparam int LW = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [LW-1:0] la;
      logic [LW-1:0] lv;
      logic [DW-1:0] da;
      logic [DW-1:0] dv;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic [NR-1:0]      req_valid;
   logic [NR*HV-1:0]   req_hv;
   logic               am_ready;
   logic               model_valid;
   logic               stray_valid;
   logic [LW-1:0]      model_la, model_lv;
   logic [DW-1:0]      model_da, model_dv;
   logic [NR-1:0]      resp_ready;

   logic [NR-1:0]      ReqReady_SO, RespValid_SO;
   logic               AmValid_SO, AmReady_SO, Busy_SO;
   logic [HV-1:0]      AmHypervector_DO;
   logic [IW-1:0]      RespId_DO;
   logic [LW-1:0]      RespLabelA_DO, RespLabelV_DO;
   logic [DW-1:0]      RespDistA_DO, RespDistV_DO;
   logic [15:0]        QueryCount_DO;

   int   tests;
   int   fails;
   int   bptr;
   int   exp_count;
   int   am_lat;
   exp_t exp_q[$];
   int   grant_log[$];

   am_query_arbiter #(.NUM_REQ(NR), .HV_DIM(HV), .LABEL_W(LW), .DIST_W(DW), .ID_W(IW)) dut (
      .Clk_CI(clk), .Rst_RBI(rst_n),
      .ReqValid_SI(req_valid), .ReqReady_SO(ReqReady_SO), .ReqHypervector_DI(req_hv),
      .AmValid_SO(AmValid_SO), .AmReady_SI(am_ready), .AmHypervector_DO(AmHypervector_DO),
      .AmValid_SI(model_valid | stray_valid), .AmReady_SO(AmReady_SO),
      .AmLabelA_DI(model_la), .AmLabelV_DI(model_lv), .AmDistA_DI(model_da), .AmDistV_DI(model_dv),
      .RespValid_SO(RespValid_SO), .RespReady_SI(resp_ready), .RespId_DO(RespId_DO),
      .RespLabelA_DO(RespLabelA_DO), .RespLabelV_DO(RespLabelV_DO),
      .RespDistA_DO(RespDistA_DO), .RespDistV_DO(RespDistV_DO),
      .QueryCount_DO(QueryCount_DO), .Busy_SO(Busy_SO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [HV-1:0] hv_of(input int i);
      return req_hv[i*HV +: HV];
   endfunction

   // The AM behaviour used here: result fields are slices of the query.
   function automatic exp_t make_exp(input int id, input logic [HV-1:0] hv);
      exp_t e;
      e.id = IW'(id);
      e.la = hv[3:0];
      e.lv = hv[7:4];
      e.da = hv[15:8];
      e.dv = hv[23:16];
      return e;
   endfunction

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] r;
      r = '0;
      if (i >= 0 && i < NR) r[i] = 1'b1;
      return r;
   endfunction

   function automatic int rr_pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++) begin
         int idx;
         idx = (p + k) % NR;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // Behavioural AM: accepts a query, answers after am_lat cycles, holds until consumed.
   initial begin : am_model
      logic [HV-1:0] hv_m;
      bit            aborted;
      model_valid = 1'b0;
      model_la = '0; model_lv = '0; model_da = '0; model_dv = '0;
      forever begin
         @(negedge clk); #2;
         if (rst_n && AmValid_SO && am_ready) begin
            hv_m    = AmHypervector_DO;
            aborted = 1'b0;
            for (int c = 0; c < am_lat && !aborted; c++) begin
               @(negedge clk); #2;
               if (!rst_n) aborted = 1'b1;
            end
            if (!aborted) begin
               model_la    = hv_m[3:0];
               model_lv    = hv_m[7:4];
               model_da    = hv_m[15:8];
               model_dv    = hv_m[23:16];
               model_valid = 1'b1;
               while (model_valid) begin
                  if (!rst_n) model_valid = 1'b0;
                  else if (AmReady_SO) begin
                     @(negedge clk); #2;
                     model_valid = 1'b0;
                  end else begin
                     @(negedge clk); #2;
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bptr = 0;
      exp_count = 0;
      exp_q.delete();
      grant_log.delete();
   endtask

   // Runs requests until n responses are consumed; checks grants, issue and responses.
   task automatic serve(input int n, input bit drop);
      int   done, cyc, gid, pred;
      bit   just_granted, acked;
      exp_t e;
      done = 0; cyc = 0; gid = 0; just_granted = 1'b0; acked = 1'b0;
      while (done < n && cyc < 3000) begin
         #1;
         if (acked) begin
            resp_ready = '0;
            acked = 1'b0;
            done++;
            if (exp_count < 65535) exp_count++;
         end
         if (done == n) begin
            req_valid = '0;
         end else begin
            if (just_granted) begin
               tests++;
               if (AmValid_SO !== 1'b1 || AmHypervector_DO !== hv_of(gid)) begin
                  fails++;
                  $display("FAIL am_issue: got valid=%b hv=%h expected valid=1 hv=%h", AmValid_SO, AmHypervector_DO, hv_of(gid));
               end
               if (drop) req_valid[gid] = 1'b0;
               just_granted = 1'b0;
            end
            if (ReqReady_SO != '0) begin
               pred = rr_pick(req_valid, bptr);
               tests++;
               if (exp_q.size() != 0 || ReqReady_SO !== onehot(pred)) begin
                  fails++;
                  $display("FAIL grant: got %b expected %b (outstanding %0d)", ReqReady_SO, onehot(pred), exp_q.size());
               end
               if (pred >= 0) begin
                  exp_q.push_back(make_exp(pred, hv_of(pred)));
                  grant_log.push_back(pred);
                  gid = pred;
                  just_granted = 1'b1;
               end
            end
            if (RespValid_SO != '0) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_resp: got valid=%b expected none", RespValid_SO);
               end else begin
                  e = exp_q.pop_front();
                  if (RespValid_SO !== onehot(int'(e.id)) || RespId_DO !== e.id || RespLabelA_DO !== e.la ||
                      RespLabelV_DO !== e.lv || RespDistA_DO !== e.da || RespDistV_DO !== e.dv) begin
                     fails++;
                     $display("FAIL response: got v=%b id=%0d la=%0d lv=%0d da=%0d dv=%0d expected v=%b id=%0d la=%0d lv=%0d da=%0d dv=%0d",
                              RespValid_SO, RespId_DO, RespLabelA_DO, RespLabelV_DO, RespDistA_DO, RespDistV_DO,
                              onehot(int'(e.id)), e.id, e.la, e.lv, e.da, e.dv);
                  end
                  resp_ready = onehot(int'(e.id));
                  bptr = (int'(e.id) == NR - 1) ? 0 : int'(e.id) + 1;
                  acked = 1'b1;
               end
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (done < n) begin
         tests++; fails++;
         $display("FAIL serve_timeout: got %0d responses expected %0d", done, n);
         req_valid = '0;
         resp_ready = '0;
      end
      tests++;
      if (QueryCount_DO !== 16'(exp_count)) begin
         fails++;
         $display("FAIL query_count: got %0d expected %0d", QueryCount_DO, exp_count);
      end
   endtask

   task automatic test_reset;
      #1;
      tests++;
      if (ReqReady_SO !== 4'b0000 || RespValid_SO !== 4'b0000 || AmValid_SO !== 1'b0 || AmReady_SO !== 1'b0) begin
         fails++;
         $display("FAIL reset_handshakes: got rr=%b rv=%b av=%b ar=%b expected all 0", ReqReady_SO, RespValid_SO, AmValid_SO, AmReady_SO);
      end
      tests++;
      if (Busy_SO !== 1'b0 || QueryCount_DO !== 16'd0 || RespId_DO !== 2'd0) begin
         fails++;
         $display("FAIL reset_state: got busy=%b cnt=%0d id=%0d expected 0 0 0", Busy_SO, QueryCount_DO, RespId_DO);
      end
      tests++;
      if (AmHypervector_DO !== 64'd0 || RespLabelA_DO !== 4'd0 || RespDistA_DO !== 8'd0 || RespDistV_DO !== 8'd0) begin
         fails++;
         $display("FAIL reset_regs: got hv=%h la=%0d da=%0d dv=%0d expected zeros", AmHypervector_DO, RespLabelA_DO, RespDistA_DO, RespDistV_DO);
      end
      @(negedge clk);
   endtask

   task automatic test_single;
      req_hv[2*HV +: HV] = 64'hDEAD_BEEF_C35A_7803;
      am_lat = 10;
      grant_log.delete();
      req_valid = 4'b0100;
      serve(1, 1'b1);
      tests++;
      if (grant_log.size() != 1 || grant_log[0] != 2) begin
         fails++;
         $display("FAIL single_grant: got %0d grants expected one grant to 2", grant_log.size());
      end
      tests++;
      if (RespId_DO !== 2'd2 || RespLabelA_DO !== 4'd3 || RespDistA_DO !== 8'd120 || QueryCount_DO !== 16'd1) begin
         fails++;
         $display("FAIL single_result: got id=%0d la=%0d da=%0d cnt=%0d expected 2 3 120 1", RespId_DO, RespLabelA_DO, RespDistA_DO, QueryCount_DO);
      end
      am_lat = 2;
   endtask

   task automatic test_simultaneous;
      int order[5];
      order = '{0, 1, 2, 3, 0};
      grant_log.delete();
      req_valid = 4'b1111;
      serve(5, 1'b0);
      tests++;
      if (grant_log.size() != 5) begin
         fails++;
         $display("FAIL simul_count: got %0d grants expected 5", grant_log.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (grant_log[i] != order[i]) begin
               fails++;
               $display("FAIL simul_order: grant %0d got %0d expected %0d", i, grant_log[i], order[i]);
               break;
            end
         end
      end
   endtask

   task automatic test_rr_pointer;
      req_valid = 4'b0100;
      serve(1, 1'b1);
      grant_log.delete();
      req_valid = 4'b1010;
      serve(2, 1'b1);
      tests++;
      if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 1) begin
         fails++;
         $display("FAIL rr_pointer: got %0d grants first=%0d expected order 3,1", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
      end
   endtask

   task automatic test_stray;
      logic [15:0] cnt0;
      #1;
      cnt0 = QueryCount_DO;
      stray_valid = 1'b1;
      tests++;
      if (AmReady_SO !== 1'b0 || Busy_SO !== 1'b0) begin
         fails++;
         $display("FAIL stray_ready: got ar=%b busy=%b expected 0 0", AmReady_SO, Busy_SO);
      end
      @(negedge clk); #1;
      stray_valid = 1'b0;
      tests++;
      if (Busy_SO !== 1'b0 || AmValid_SO !== 1'b0 || RespValid_SO !== 4'b0000 || QueryCount_DO !== cnt0) begin
         fails++;
         $display("FAIL stray_state: got busy=%b av=%b rv=%b cnt=%0d expected 0 0 0000 %0d", Busy_SO, AmValid_SO, RespValid_SO, QueryCount_DO, cnt0);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int   pred;
      int   waited;
      exp_t e;
      am_lat = 3;
      am_ready = 1'b0;
      req_hv[0 +: HV] = 64'h1357_9BDF_2468_ACE5;
      req_valid = 4'b0001;
      #1;
      pred = rr_pick(req_valid, bptr);
      tests++;
      if (ReqReady_SO !== onehot(pred)) begin
         fails++;
         $display("FAIL bp_grant: got %b expected %b", ReqReady_SO, onehot(pred));
      end
      exp_q.push_back(make_exp(pred, hv_of(pred)));
      @(negedge clk); #1;
      req_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (AmValid_SO !== 1'b1 || AmHypervector_DO !== hv_of(0) || ReqReady_SO !== 4'b0000) begin
            fails++;
            $display("FAIL bp_issue_hold: cycle %0d got av=%b hv=%h rr=%b expected 1 %h 0000", i, AmValid_SO, AmHypervector_DO, ReqReady_SO, hv_of(0));
         end
         @(negedge clk); #1;
      end
      am_ready = 1'b1;
      waited = 0;
      while (RespValid_SO == '0 && waited < 100) begin
         @(negedge clk); #1;
         waited++;
      end
      e = exp_q.pop_front();
      for (int i = 0; i < 7; i++) begin
         tests++;
         if (RespValid_SO !== onehot(int'(e.id)) || RespId_DO !== e.id || RespLabelA_DO !== e.la || RespLabelV_DO !== e.lv ||
             RespDistA_DO !== e.da || RespDistV_DO !== e.dv || ReqReady_SO !== 4'b0000) begin
            fails++;
            $display("FAIL bp_resp_hold: cycle %0d got rv=%b id=%0d la=%0d da=%0d rr=%b expected %b %0d %0d %0d 0000",
                     i, RespValid_SO, RespId_DO, RespLabelA_DO, RespDistA_DO, ReqReady_SO, onehot(int'(e.id)), e.id, e.la, e.da);
         end
         @(negedge clk); #1;
      end
      resp_ready = onehot(int'(e.id));
      bptr = (int'(e.id) == NR - 1) ? 0 : int'(e.id) + 1;
      exp_count++;
      @(negedge clk);
      resp_ready = '0;
      serve(1, 1'b1);
      am_lat = 2;
   endtask

   task automatic test_reset_mid;
      int pred;
      int waited;
      am_lat = 20;
      req_valid = 4'b1000;
      #1;
      pred = rr_pick(req_valid, bptr);
      tests++;
      if (ReqReady_SO !== onehot(pred)) begin
         fails++;
         $display("FAIL rm_grant: got %b expected %b", ReqReady_SO, onehot(pred));
      end
      @(negedge clk);
      req_valid = '0;
      waited = 0;
      while (waited < 50) begin
         @(negedge clk); #1;
         waited++;
         if (AmReady_SO) break;
      end
      tests++;
      if (AmReady_SO !== 1'b1) begin
         fails++;
         $display("FAIL rm_wait_res: got ar=%b expected 1", AmReady_SO);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (Busy_SO !== 1'b0 || AmReady_SO !== 1'b0 || AmValid_SO !== 1'b0 || RespValid_SO !== 4'b0000 ||
          QueryCount_DO !== 16'd0 || RespId_DO !== 2'd0 || AmHypervector_DO !== 64'd0) begin
         fails++;
         $display("FAIL rm_async_clear: got busy=%b ar=%b av=%b rv=%b cnt=%0d id=%0d hv=%h expected all 0",
                  Busy_SO, AmReady_SO, AmValid_SO, RespValid_SO, QueryCount_DO, RespId_DO, AmHypervector_DO);
      end
      req_valid = 4'b1100;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      am_lat = 2;
      bptr = 0;
      exp_count = 0;
      exp_q.delete();
      grant_log.delete();
      serve(2, 1'b1);
      tests++;
      if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 3) begin
         fails++;
         $display("FAIL rm_after_reset: got %0d grants first=%0d expected order 2,3", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
      end
   endtask

   initial begin
      tests = 0; fails = 0; bptr = 0; exp_count = 0; am_lat = 2;
      rst_n = 1'b0;
      req_valid = '0;
      resp_ready = '0;
      am_ready = 1'b1;
      stray_valid = 1'b0;
      for (int i = 0; i < NR; i++) req_hv[i*HV +: HV] = {$urandom(), $urandom()};
      apply_reset();
      test_reset();
      test_single();
      apply_reset();
      test_simultaneous();
      test_rr_pointer();
      test_stray();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
